// File: rtl/mult_bist_ctrl.sv
// BIST controller for the 8-bit approximate multiplier: drives counter or LFSR
// stimulus, waits a settle time, captures each response and compacts it in a MISR.
module mult_bist_ctrl #(
  parameter int unsigned          BIT_WIDTH     = 8,
  parameter int unsigned          OUT_WIDTH     = 16,
  parameter int unsigned          NUM_VECTORS   = 256,
  parameter int unsigned          SETTLE_CYCLES = 1,
  parameter logic [BIT_WIDTH-1:0] LFSR_SEED     = 8'h01
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 mode,
  output logic [BIT_WIDTH-1:0] dut_inp,
  input  logic [OUT_WIDTH-1:0] dut_out,
  output logic                 cap_valid,
  output logic [OUT_WIDTH-1:0] cap_data,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          vec_count,
  output logic [OUT_WIDTH-1:0] signature
);

  localparam int unsigned          CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [15:0]          NV       = 16'(NUM_VECTORS);
  localparam logic [OUT_WIDTH-1:0] POLY     = OUT_WIDTH'(16'h1021);
  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [BIT_WIDTH-1:0] SEED     = (LFSR_SEED == '0) ? BIT_WIDTH'(1) : LFSR_SEED;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CAPTURE, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     settle_q, settle_d;
  logic                 mode_q, mode_d;
  logic [BIT_WIDTH-1:0] stim_q, stim_d, stim_next;
  logic                 cap_valid_q, cap_valid_d;
  logic [OUT_WIDTH-1:0] cap_data_q, cap_data_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [15:0]          vec_count_q, vec_count_d, vec_count_inc;
  logic [OUT_WIDTH-1:0] signature_q, signature_d;
  logic                 lfsr_fb;

  always_comb begin
    lfsr_fb       = stim_q[7] ^ stim_q[5] ^ stim_q[4] ^ stim_q[3];
    stim_next     = mode_q ? {stim_q[BIT_WIDTH-2:0], lfsr_fb} : stim_q + BIT_WIDTH'(1);
    vec_count_inc = vec_count_q + 16'd1;
  end

  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    mode_d      = mode_q;
    stim_d      = stim_q;
    cap_valid_d = 1'b0;
    cap_data_d  = cap_data_q;
    busy_d      = busy_q;
    done_d      = done_q;
    vec_count_d = vec_count_q;
    signature_d = signature_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          settle_d    = '0;
          signature_d = '0;
          vec_count_d = '0;
          mode_d      = mode;
          stim_d      = mode ? SEED : '0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          state_d     = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (settle_q == CNT_LAST) begin
          settle_d = '0;
          state_d  = S_CAPTURE;
        end else begin
          settle_d = settle_q + CNT_W'(1);
        end
      end
      S_CAPTURE: begin
        signature_d = {signature_q[OUT_WIDTH-2:0], 1'b0}
                    ^ (signature_q[OUT_WIDTH-1] ? POLY : '0)
                    ^ dut_out;
        cap_data_d  = dut_out;
        cap_valid_d = 1'b1;
        vec_count_d = vec_count_inc;
        stim_d      = stim_next;
        if (vec_count_inc == NV) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_DRIVE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      settle_q    <= '0;
      mode_q      <= 1'b0;
      stim_q      <= '0;
      cap_valid_q <= 1'b0;
      cap_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      vec_count_q <= '0;
      signature_q <= '0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      mode_q      <= mode_d;
      stim_q      <= stim_d;
      cap_valid_q <= cap_valid_d;
      cap_data_q  <= cap_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      vec_count_q <= vec_count_d;
      signature_q <= signature_d;
    end
  end

  assign dut_inp   = stim_q;
  assign cap_valid = cap_valid_q;
  assign cap_data  = cap_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign vec_count = vec_count_q;
  assign signature = signature_q;

endmodule

// File: tb/tb_mult_bist_ctrl.sv
// Scoreboard bench for mult_bist_ctrl: a behavioural model queues the expected
// captures of each run, and a monitor checks them as cap_valid pulses appear.
module tb_mult_bist_ctrl;

  localparam int unsigned NV_A = 256, ST_A = 3;
  localparam int unsigned NV_B = 4,   ST_B = 1;

  typedef struct {
    logic [15:0] data;
    logic [15:0] cnt;
    logic [15:0] sig;
    int unsigned off;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start_a = 1'b0, mode_a = 1'b0;
  logic [7:0]  inp_a;
  logic [15:0] dout_a, cdata_a, vc_a, sig_a;
  logic        cv_a, busy_a, done_a;

  logic        start_b = 1'b0, mode_b = 1'b0;
  logic [7:0]  inp_b;
  logic [15:0] dout_b, cdata_b, vc_b, sig_b;
  logic        cv_b, busy_b, done_b;

  int unsigned fsel_a = 0, fsel_b = 0;
  logic [15:0] k_a = '0, k_b = '0;

  int unsigned n_cmp = 0, n_bad = 0;
  int unsigned edge_n = 0;
  int unsigned start_edge_a = 0;
  exp_t        sb_q[$];
  exp_t        mq[$];
  exp_t        e;
  bit          lfsr_chk = 1'b0;
  bit          seen[256];
  logic [7:0]  first5[5];

  // Stand-in for the multiplier under test: several response shapes.
  function automatic logic [15:0] resp(input int unsigned fsel, input logic [15:0] k,
                                       input logic [7:0] x);
    case (fsel)
      0:       return {8'h00, x};
      1:       return 16'(x) * 16'(k[7:0]);
      2:       return k;
      default: return {x, x} ^ k;
    endcase
  endfunction

  always_comb dout_a = resp(fsel_a, k_a, inp_a);
  always_comb dout_b = resp(fsel_b, k_b, inp_b);

  mult_bist_ctrl #(
    .BIT_WIDTH(8), .OUT_WIDTH(16), .NUM_VECTORS(NV_A),
    .SETTLE_CYCLES(ST_A), .LFSR_SEED(8'h01)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .mode(mode_a),
    .dut_inp(inp_a), .dut_out(dout_a), .cap_valid(cv_a), .cap_data(cdata_a),
    .busy(busy_a), .done(done_a), .vec_count(vc_a), .signature(sig_a)
  );

  mult_bist_ctrl #(
    .BIT_WIDTH(8), .OUT_WIDTH(16), .NUM_VECTORS(NV_B),
    .SETTLE_CYCLES(ST_B), .LFSR_SEED(8'h00)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .mode(mode_b),
    .dut_inp(inp_b), .dut_out(dout_b), .cap_valid(cv_b), .cap_data(cdata_b),
    .busy(busy_b), .done(done_b), .vec_count(vc_b), .signature(sig_b)
  );

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [15:0] d);
    return (s << 1) ^ (s[15] ? 16'h1021 : 16'h0000) ^ d;
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  // Reference model: walks the vector list and fills mq with expected captures.
  task automatic build(input logic m, input int unsigned n, input int unsigned st,
                       input logic [7:0] seed, input int unsigned fsel, input logic [15:0] k,
                       output logic [15:0] fsig, output logic [7:0] fstim, output logic [7:0] v0);
    logic [7:0]  x;
    logic [15:0] s, d;
    exp_t        t;
    mq.delete();
    x  = m ? seed : 8'h00;
    v0 = x;
    s  = '0;
    for (int unsigned i = 0; i < n; i++) begin
      d      = resp(fsel, k, x);
      s      = misr_step(s, d);
      t.data = d;
      t.cnt  = 16'(i + 1);
      t.sig  = s;
      t.off  = (i + 1) * (st + 1);
      mq.push_back(t);
      x = m ? lfsr_next(x) : 8'((int'(x) + 1) % 256);
    end
    fsig  = s;
    fstim = x;
  endtask

  always @(negedge clk) begin
    if (rst_n && cv_a) begin
      if (sb_q.size() == 0) begin
        chk("a_unexpected_cap", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("a_cap_data", cdata_a, e.data);
        chk("a_vec_count", vc_a, e.cnt);
        chk("a_signature", sig_a, e.sig);
        chk("a_cap_timing", edge_n - start_edge_a, e.off);
        if (lfsr_chk && e.cnt <= 16'd255) begin
          chk("a_lfsr_unique", {31'd0, seen[cdata_a[7:0]]}, 32'd0);
          chk("a_lfsr_nonzero", {31'd0, cdata_a[7:0] == 8'h00}, 32'd0);
          seen[cdata_a[7:0]] = 1'b1;
          if (e.cnt <= 16'd5) chk("a_lfsr_seq", cdata_a[7:0], first5[e.cnt - 1]);
        end
      end
    end
  end

  task automatic chk_reset_a(input string tag);
    chk({tag, "_inp"}, inp_a, 0);
    chk({tag, "_cap_valid"}, cv_a, 0);
    chk({tag, "_cap_data"}, cdata_a, 0);
    chk({tag, "_busy"}, busy_a, 0);
    chk({tag, "_done"}, done_a, 0);
    chk({tag, "_vec_count"}, vc_a, 0);
    chk({tag, "_signature"}, sig_a, 0);
  endtask

  task automatic start_run_a(input logic m, input int unsigned fsel, input logic [15:0] k,
                             output logic [15:0] fs, output logic [7:0] fst);
    logic [7:0] v0;
    fsel_a = fsel;
    k_a    = k;
    build(m, NV_A, ST_A, 8'h01, fsel, k, fs, fst, v0);
    sb_q.delete();
    foreach (mq[i]) sb_q.push_back(mq[i]);
    @(negedge clk);
    start_a      = 1'b1;
    mode_a       = m;
    start_edge_a = edge_n + 1;
    @(negedge clk);
    start_a = 1'b0;
    mode_a  = ~m;
    chk("a_start_busy", busy_a, 1);
    chk("a_start_done", done_a, 0);
    chk("a_start_sig", sig_a, 0);
    chk("a_start_vc", vc_a, 0);
    chk("a_start_inp", inp_a, v0);
  endtask

  task automatic run_a(input logic m, input int unsigned fsel, input logic [15:0] k,
                       input bit pulse);
    logic [15:0] fs;
    logic [7:0]  fst;
    int unsigned t;
    start_run_a(m, fsel, k, fs, fst);
    t = 0;
    while (!done_a && t < NV_A * (ST_A + 1) + 20) begin
      @(negedge clk);
      t++;
      start_a = pulse && (t % 97 == 37);
      mode_a  = 1'($urandom);
    end
    start_a = 1'b0;
    chk("a_done", done_a, 1);
    chk("a_busy_end", busy_a, 0);
    chk("a_run_len", edge_n - start_edge_a, NV_A * (ST_A + 1));
    chk("a_final_vc", vc_a, NV_A);
    chk("a_final_sig", sig_a, fs);
    chk("a_final_inp", inp_a, fst);
    repeat (3) @(negedge clk);
    chk("a_sig_frozen", sig_a, fs);
    chk("a_cv_low_done", cv_a, 0);
    chk("a_queue_empty", sb_q.size(), 0);
  endtask

  task automatic run_b(input logic m, input int unsigned fsel, input logic [15:0] k,
                       output logic [15:0] fs);
    logic [7:0]  fst, v0;
    int unsigned np, se;
    fsel_b = fsel;
    k_b    = k;
    build(m, NV_B, ST_B, 8'h01, fsel, k, fs, fst, v0);
    @(negedge clk);
    start_b = 1'b1;
    mode_b  = m;
    se      = edge_n + 1;
    @(negedge clk);
    start_b = 1'b0;
    chk("b_inp0", inp_b, v0);
    np = 0;
    for (int i = 0; i < 12; i++) begin
      if (cv_b) begin
        if (np < mq.size()) begin
          chk("b_cap_data", cdata_b, mq[np].data);
          chk("b_cap_timing", edge_n - se, mq[np].off);
        end
        np++;
      end
      if (done_b) break;
      @(negedge clk);
    end
    chk("b_pulses", np, NV_B);
    chk("b_done", done_b, 1);
    chk("b_done_cycle", edge_n - se, NV_B * (ST_B + 1));
    chk("b_vc", vc_b, NV_B);
    chk("b_sig", sig_b, fs);
  endtask

  initial begin
    logic [15:0] fs;
    logic [7:0]  fst;
    int unsigned t;
    first5[0] = 8'h01; first5[1] = 8'h02; first5[2] = 8'h04;
    first5[3] = 8'h08; first5[4] = 8'h11;

    repeat (3) @(negedge clk);
    chk_reset_a("rst");
    chk("rst_b_sig", sig_b, 0);
    rst_n = 1'b1;

    run_b(1'b0, 0, 16'h0000, fs);
    chk("b_counter_sig_const", sig_b, 16'h0003);
    run_b(1'b0, 2, 16'h0001, fs);
    run_b(1'b1, 2, 16'h0000, fs);
    chk("b_tie0_sig", sig_b, 16'h0000);
    run_b(1'b1, 0, 16'h0000, fs);

    run_a(1'b0, 0, 16'h0000, 1'b0);
    foreach (seen[i]) seen[i] = 1'b0;
    lfsr_chk = 1'b1;
    run_a(1'b1, 0, 16'h0000, 1'b1);
    lfsr_chk = 1'b0;
    for (int r = 0; r < 3; r++)
      run_a(1'($urandom), $urandom_range(0, 3), 16'($urandom), 1'b1);

    start_run_a(1'b0, 1, 16'h00B7, fs, fst);
    t = 0;
    while (vc_a != 16'd2 && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    chk("mid_inp_vec3", inp_a, 8'h02);
    #2 rst_n = 1'b0;
    #1 chk_reset_a("midrst");
    @(negedge clk);
    chk_reset_a("midrst_held");
    rst_n = 1'b1;
    sb_q.delete();
    run_a(1'b0, 1, 16'h00B7, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mult_bist_ctrl.md
# mult_bist_ctrl

On-chip built-in self-test controller for the combinational 8-bit approximate multiplier circuits (`top`: `inp` → `out`). It drives stimulus into the multiplier's input, waits a programmable settle time, and captures each response. Each response is streamed out as a one-cycle capture beat and compacted into a 16-bit MISR signature. The block replaces the file-driven stimulus/capture loop with synthesizable hardware so the same circuit can be characterised on silicon.

## Interface
- `BIT_WIDTH`, 8: DUT input width. Must be 8 when LFSR mode is used.
- `OUT_WIDTH`, 16: DUT output width and MISR width. Must be 16.
- `NUM_VECTORS`, 256: vectors applied per run. Range 1..65535.
- `SETTLE_CYCLES`, 1: cycles `dut_inp` is held before capture. Minimum 1.
- `LFSR_SEED`, 8'h01: LFSR start value. A value of 0 is replaced by 8'h01.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: run request. Sampled only in IDLE or DONE.
- `mode` in 1: stimulus source. 0 = exhaustive counter, 1 = LFSR. Sampled with `start`.
- `dut_inp` out BIT_WIDTH: stimulus to the DUT input.
- `dut_out` in OUT_WIDTH: DUT response.
- `cap_valid` out 1: one-cycle pulse per captured vector.
- `cap_data` out OUT_WIDTH: captured response. Valid while `cap_valid`=1.
- `busy` out 1: run in progress.
- `done` out 1: run complete. Level signal.
- `vec_count` out 16: vectors captured so far in the current run.
- `signature` out OUT_WIDTH: MISR contents.

## Operation
- FSM states: IDLE, DRIVE, CAPTURE, DONE. Reset state is IDLE.
- IDLE/DONE, `start`=1:
  - clear `signature`, `vec_count` and the settle counter;
  - latch `mode`;
  - load the stimulus register: 0 for counter mode, the seed for LFSR mode;
  - go to DRIVE.
- DRIVE:
  - `dut_inp` shows the stimulus register;
  - the settle counter counts SETTLE_CYCLES cycles, then the FSM goes to CAPTURE.
- CAPTURE (exactly one cycle), at its closing edge:
  - `signature` ← {signature[14:0],1'b0} ^ (signature[15] ? 16'h1021 : 16'h0) ^ `dut_out`;
  - `cap_data` ← `dut_out`; `cap_valid` pulses high for the next cycle;
  - `vec_count` increments;
  - the stimulus register advances;
  - if the new `vec_count` equals NUM_VECTORS, go to DONE; otherwise go to DRIVE.
- Counter stimulus: +1 modulo 2^BIT_WIDTH. 255 wraps to 0.
- LFSR stimulus: Fibonacci, polynomial x^8+x^6+x^5+x^4+1.
  - fb = q[7]^q[5]^q[4]^q[3]; next = {q[6:0], fb}.
  - Period 255; the value 0 never occurs.
- DONE: `done`=1 and `signature` is frozen until the next `start` or reset.
- `start` during DRIVE or CAPTURE is ignored.
- `mode` is ignored except when sampled with `start`.

## Timing
- Reset values: `dut_inp`=0, `cap_valid`=0, `cap_data`=0, `busy`=0, `done`=0, `vec_count`=0, `signature`=0.
- All outputs are registered.
- `start` is seen at edge k. From the cycle after edge k, `busy`=1 and `dut_inp` holds vector 0.
- Each vector takes SETTLE_CYCLES+1 cycles. `dut_inp` is stable for all of them; `dut_out` is sampled at the closing edge of CAPTURE.
- Total run: NUM_VECTORS×(SETTLE_CYCLES+1) cycles. `busy` falls and `done` rises in the same cycle as the last `cap_valid` pulse.
- `cap_valid` and the updated `signature`/`vec_count` appear together in the cycle after the capture edge.
- `start` in DONE: `done` drops on the next cycle and the new run begins exactly as from IDLE.
- `rst_n` low at any time, including mid-run: all outputs return to their reset values immediately (asynchronous) and the FSM goes to IDLE. Operation resumes on the first edge after `rst_n` rises.

## Test plan
- Counter mode, NUM_VECTORS=4, SETTLE_CYCLES=1, `dut_out`={8'h0,`dut_inp`}:
  - `cap_data` pulses carry 0,1,2,3, two cycles apart;
  - final `signature`=16'h0003, `vec_count`=4, `done`=1 at cycle 8 after start.
- LFSR mode, seed 8'h01: `dut_inp` sequence is 01,02,04,08,11. Over 255 vectors no value repeats and 0 never appears.
- `dut_out` tied to 16'h0001, NUM_VECTORS=2: `signature`=16'h0003. With `dut_out` tied to 0, `signature` stays 16'h0000.
- `start` pulsed mid-run: no effect on `dut_inp` sequence, count or signature. `start` in DONE restarts: `signature`=0 and `done`=0 next cycle.
- `rst_n` asserted during the 3rd vector: all outputs go to reset values at once. A new start gives the same signature as an uninterrupted run.
- SETTLE_CYCLES=3, counter mode, NUM_VECTORS=256: `dut_inp` is held 4 cycles per vector and wraps 255→0 only after the run ends. `vec_count`=256 and `done` is asserted at cycle 1024.
